mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//   MEM-stage load/store controller placed directly upstream of the word-wide data memory.
//   Accepts byte, halfword and word load/store requests from the pipeline.
//   Maps each request onto the memory's word-only we/re/addr interface.
//   Sub-word stores use a read-modify-write sequence; load data is extracted and sign/zero-extended.
// PARAMETERS
//   MEM_BYTES  4096  bytes of backing memory; byte addresses >= MEM_BYTES are out of range
// PORTS
//   clk          in   1   single clock, all state updates on posedge
//   rst          in   1   synchronous, active-high reset
//   req_valid    in   1   request present
//   req_ready    out  1   unit idle, can accept; transfer when req_valid && req_ready
//   req_op       in   3   mem_op_e: LB, LBU, LH, LHU, LW, SB, SH, SW
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
//   resp_valid   out  1   one-cycle pulse, completion of the accepted request
//   resp_rdata   out  32  extended load data; 0 for stores and errors
//   resp_err     out  1   misaligned or out-of-range; no memory access was made
//   dmem_re      out  1   memory read enable
//   dmem_we      out  1   memory write enable; write lands at the posedge ending the cycle
//   dmem_addr    out  32  word-aligned address, {addr[31:2],2'b00}
//   dmem_wdata   out  32  full word to write
//   dmem_rdata   in   32  combinational read data; valid only while dmem_re=1
// BEHAVIOUR
//   - Little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; halfword at addr[1] selects [31:16] or [15:0].
//   - Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0,
//     dmem_re=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
//   - FSM: IDLE, LOAD, RMW_RD, STORE, RESP.
//     - req_ready=1 only in IDLE.
//     - On acceptance, op/addr/wdata are latched; req_* is ignored until the unit returns to IDLE.
//   - IDLE -> RESP with err=1 if addr >= MEM_BYTES or the request is misaligned (see CONFIGURATION).
//   - IDLE -> LOAD for LB/LBU/LH/LHU/LW; IDLE -> STORE for SW; IDLE -> RMW_RD for SB/SH.
//   - LOAD: dmem_re=1. Extract and extend dmem_rdata into resp_rdata at the posedge. -> RESP.
//   - RMW_RD: dmem_re=1. Merge the new byte/halfword into dmem_rdata and hold the result in a word buffer. -> STORE.
//   - STORE: dmem_we=1; dmem_wdata = latched wdata for SW, word buffer otherwise. -> RESP.
//   - RESP: resp_valid=1 for exactly one cycle. -> IDLE. The pipeline cannot back-pressure the response.
//   - Latency, counted from the acceptance edge to the resp_valid cycle:
//     load = 2 cycles, SW = 2 cycles, SB/SH = 3 cycles, error = 1 cycle.
//   - dmem_re and dmem_we are never both 1. Both are 0 outside LOAD/RMW_RD/STORE; dmem_rdata (Z) is ignored there.
//   - Sign extension: LB/LH replicate bit 7/15; LBU/LHU zero-fill.
//   - resp_rdata/resp_err hold their value after RESP until the next completion.
//   - Reset asserted in any state: returns to IDLE next edge and aborts the request.
//     No write is issued unless rst was low during the STORE cycle.
//   - Back-to-back: a new request may be accepted in the IDLE cycle immediately after RESP.
// CONFIGURATION
//   MEM_ACCESS_ALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0,
//     complete with resp_err=1 and no memory access.
//   MEM_ACCESS_ALIGN_TRAP_EN undefined: misalignment is not an error.
//     The low address bits are forced to the access size (halfword addr[0]=0, word addr[1:0]=0)
//     and the access proceeds. Out-of-range is still an error.
// STRUCTURE
//   - mem_access_pkg: mem_op_e enum, state_e enum, and helpers is_load/is_store/size_of.
//   - Sub-module mem_byte_lane (combinational): load extract/extend and store merge, from op, addr[1:0], word in.
//   - Top module holds the FSM, request latches and output registers.
// TESTING
//   1 SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> dmem_we one cycle, word[4]=0xDEADBEEF;
//     LW resp_rdata=0xDEADBEEF, resp_valid 2 cycles after acceptance.
//   2 word[4]=0x11223344; SB addr=0x12 data=0xAA -> RMW read then write, word[4]=0x11AA3344, 3-cycle latency.
//   3 word[4]=0x80FF7F01; LB 0x13=0xFFFFFF80, LBU 0x13=0x00000080, LH 0x10=0x00007F01, LHU 0x12=0x000080FF.
//   4 With ALIGN_TRAP_EN: LW 0x11 -> resp_err=1 after 1 cycle, dmem_re/we stay 0;
//     without ALIGN_TRAP_EN: LW 0x11 reads word[4].
//   5 LW addr=MEM_BYTES -> resp_err=1, resp_rdata=0, no dmem access.
//   6 SH 0x20 accepted, rst pulsed in RMW_RD -> no dmem_we, word[8] unchanged, req_ready=1 next cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        STORE  = 3'd3,
        RESP   = 3'd4
    } state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    function automatic logic is_load(input mem_op_e op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic [1:0] size_of(input mem_op_e op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return SIZE_H;
            OP_LW, OP_SW:         return SIZE_W;
            default:              return SIZE_B;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
        case (size_of(op))
            SIZE_H:  return lo[0];
            SIZE_W:  return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Clears the low address bits that fall inside the access size.
    function automatic logic [31:0] align_addr(input mem_op_e op, input logic [31:0] addr);
        case (size_of(op))
            SIZE_H:  return {addr[31:1], 1'b0};
            SIZE_W:  return {addr[31:2], 2'b00};
            default: return addr;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  byte_ofs;

    always_comb begin
        byte_ofs = {addr_lo, 3'b000};
        byte_sel = word_in[byte_ofs +: 8];
        half_sel = addr_lo[1] ? word_in[31:16] : word_in[15:0];

        load_data = word_in;
        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0, half_sel};
            default: load_data = word_in;
        endcase

        merge_data = word_in;
        case (op)
            OP_SB: merge_data[byte_ofs +: 8] = wdata[7:0];
            OP_SH: begin
                if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
                else            merge_data[15:0]  = wdata[15:0];
            end
            OP_SW:   merge_data = wdata;
            default: merge_data = word_in;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of a word-wide data memory.
// Optional MEM_ACCESS_ALIGN_TRAP_EN: misaligned halfword/word accesses complete with resp_err.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);

    state_e      state, state_next;
    mem_op_e     op_in, op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_eff;
    logic        accept, range_err, align_err, req_err;
    logic        we_q;
    logic [31:0] load_data, merge_data;

    logic        ready_d, valid_d, re_d, we_d, err_d;
    logic [31:0] rdata_d, addr_d, wdata_d;

    assign op_in  = mem_op_e'(req_op);
    assign accept = req_valid && req_ready;

    always_comb begin
        range_err = req_addr >= 32'(MEM_BYTES);
`ifdef MEM_ACCESS_ALIGN_TRAP_EN
        align_err = is_misaligned(op_in, req_addr[1:0]);
`else
        align_err = 1'b0;
`endif
        req_err  = range_err || align_err;
        addr_eff = align_addr(op_in, req_addr);
    end

    mem_byte_lane u_lane (
        .op         (op_q),
        .addr_lo    (addr_lo_q),
        .word_in    (dmem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                                        state_next = RESP;
                    else if (is_load(op_in))                            state_next = LOAD;
                    else if (is_store(op_in) && size_of(op_in) == SIZE_W) state_next = STORE;
                    else                                                state_next = RMW_RD;
                end
            end
            LOAD:    state_next = RESP;
            RMW_RD:  state_next = STORE;
            STORE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        ready_d = state_next == IDLE;
        valid_d = state_next == RESP;
        re_d    = state_next inside {LOAD, RMW_RD};
        we_d    = state_next == STORE;
        rdata_d = resp_rdata;
        err_d   = resp_err;
        addr_d  = dmem_addr;
        wdata_d = dmem_wdata;
        case (state)
            IDLE: begin
                if (accept && req_err) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end else if (accept) begin
                    addr_d = {addr_eff[31:2], 2'b00};
                    if (op_in == OP_SW) wdata_d = req_wdata;
                end
            end
            LOAD: begin
                rdata_d = load_data;
                err_d   = 1'b0;
            end
            RMW_RD: wdata_d = merge_data;
            STORE: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            dmem_re    <= 1'b0;
            we_q       <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            op_q       <= OP_LB;
            addr_lo_q  <= 2'b00;
            wdata_q    <= 32'h0;
        end else begin
            req_ready  <= ready_d;
            resp_valid <= valid_d;
            resp_rdata <= rdata_d;
            resp_err   <= err_d;
            dmem_re    <= re_d;
            we_q       <= we_d;
            dmem_addr  <= addr_d;
            dmem_wdata <= wdata_d;
            if (accept) begin
                op_q      <= op_in;
                addr_lo_q <= addr_eff[1:0];
                wdata_q   <= req_wdata;
            end
        end
    end

    // Reset arriving during STORE must suppress the write landing at that edge.
    assign dmem_we = we_q && !rst;

endmodule
